// File: rtl/text_fetch_ctrl.sv
// Text-mode character fetch scheduler: prefetches each character row into a
// double line buffer and time-shares the single-port text RAM with a CPU port.
module text_fetch_ctrl #(
    parameter int CORDW       = 11,
    parameter int COLS        = 64,
    parameter int ROWS        = 37,
    parameter int GLYPH_LINES = 16,
    parameter int AW          = $clog2(COLS*ROWS),
    parameter int STARVE      = 8
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    output logic [AW-1:0]           ram_addr,
    output logic                    ram_re,
    output logic                    ram_we,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_rdata,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [AW-1:0]           cpu_addr,
    input  logic [7:0]              cpu_wdata,
    output logic                    cpu_ack,
    output logic [7:0]              cpu_rdata,
    input  logic [$clog2(COLS)-1:0] disp_col,
    output logic [7:0]              disp_char,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int LGL = $clog2(GLYPH_LINES);
    localparam int SW  = $clog2(STARVE+1);
    localparam logic signed [CORDW:0] NLINES = (CORDW+1)'(ROWS*GLYPH_LINES);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       row, row_nxt;
    logic [CW-1:0]       col, col_nxt;
    logic [CW-1:0]       ret_col;
    logic                ret_valid;
    logic                front_sel;
    logic [SW-1:0]       cnt, cnt_nxt;
    logic                cpu_rd_pend;
    logic [7:0]          rdata_hold;
    logic [7:0]          lbuf [0:2*COLS-1];

    logic signed [CORDW:0] sy_x, n;
    logic                  trigger, swap, fetch_go, cpu_go;
    logic [RW-1:0]         trig_row;
    logic [AW-1:0]         fetch_addr;

    // n is the scanline that follows this one; a row is prefetched one line early
    assign sy_x     = {sy[CORDW-1], sy};
    assign n        = sy_x + (CORDW+1)'(1);
    assign trigger  = !rst_pix && line && !n[CORDW] && (n < NLINES)
                      && (n[LGL-1:0] == '0);
    assign swap     = !rst_pix && line && !sy_x[CORDW] && (sy_x < NLINES)
                      && (sy[LGL-1:0] == '0);
    assign trig_row = n[LGL +: RW];

    assign fetch_addr = AW'(int'(row) * COLS + int'(col));
    assign busy       = (state != IDLE);
    assign cpu_rdata  = cpu_rd_pend ? ram_rdata : rdata_hold;

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        cnt_nxt   = cnt;
        fetch_go  = 1'b0;
        cpu_go    = 1'b0;
        ram_addr  = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        cpu_ack   = 1'b0;

        if (!rst_pix) begin
            // A restart cycle issues nothing, so no beat of the old row is left in flight
            unique case (state)
                IDLE, DRAIN: cpu_go = cpu_req;
                FETCH: begin
                    if (cpu_req && (cnt == SW'(STARVE)))
                        cpu_go = 1'b1;
                    else if (!trigger)
                        fetch_go = 1'b1;
                end
                default: ;
            endcase

            if (state == DRAIN)
                state_nxt = IDLE;

            if (fetch_go) begin
                col_nxt = col + CW'(1);
                if (col == CW'(COLS-1))
                    state_nxt = DRAIN;
            end

            if (cpu_go)
                cnt_nxt = '0;
            else if (!cpu_req)
                cnt_nxt = '0;
            else if (fetch_go)
                cnt_nxt = cnt + SW'(1);

            if (trigger) begin
                state_nxt = FETCH;
                row_nxt   = trig_row;
                col_nxt   = '0;
            end

            if (cpu_go) begin
                cpu_ack   = 1'b1;
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_re    = !cpu_we;
                ram_wdata = cpu_we ? cpu_wdata : '0;
            end else if (fetch_go) begin
                ram_re   = 1'b1;
                ram_addr = fetch_addr;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            ret_col     <= '0;
            ret_valid   <= 1'b0;
            front_sel   <= 1'b0;
            cnt         <= '0;
            overrun     <= 1'b0;
            disp_char   <= '0;
            cpu_rd_pend <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            state       <= state_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            cnt         <= cnt_nxt;
            ret_valid   <= fetch_go;
            ret_col     <= col;
            cpu_rd_pend <= cpu_go && !cpu_we;
            disp_char   <= lbuf[{front_sel, disp_col}];
            if (swap)
                front_sel <= ~front_sel;
            if ((trigger && busy) || (swap && busy))
                overrun <= 1'b1;
            if (cpu_rd_pend)
                rdata_hold <= ram_rdata;
        end
    end

    // Line buffer holds no reset; a beat landing on a restart is stale and dropped
    always_ff @(posedge clk_pix) begin
        if (!rst_pix && ret_valid && !trigger)
            lbuf[{~front_sel, ret_col}] <= ram_rdata;
    end

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Directed self-checking bench for text_fetch_ctrl with a behavioural text RAM.
module tb_text_fetch_ctrl;

    logic               clk_pix = 1'b0;
    logic               rst_pix;
    logic               line;
    logic signed [10:0] sy;
    logic [11:0]        ram_addr;
    logic               ram_re, ram_we;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram_rdata = '0;
    logic               cpu_req, cpu_we;
    logic [11:0]        cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               cpu_ack;
    logic [7:0]         cpu_rdata;
    logic [5:0]         disp_col;
    logic [7:0]         disp_char;
    logic               busy, overrun;

    int errors = 0;
    int checks = 0;

    logic [4095:0] wvalid;
    logic [7:0]    wmem [0:4095];

    text_fetch_ctrl #(
        .CORDW(11), .COLS(64), .ROWS(37), .GLYPH_LINES(16), .AW(12), .STARVE(8)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .line(line), .sy(sy),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .disp_col(disp_col), .disp_char(disp_char),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic logic [7:0] pat(input int a);
        return 8'(((a * 37) + 11) ^ (a >> 5));
    endfunction

    // Unwritten locations read back the fixed pattern
    always @(posedge clk_pix) begin
        if (rst_pix)
            wvalid <= '0;
        else if (ram_we) begin
            wmem[ram_addr]   <= ram_wdata;
            wvalid[ram_addr] <= 1'b1;
        end
        if (ram_re)
            ram_rdata <= wvalid[ram_addr] ? wmem[ram_addr] : pat(int'(ram_addr));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input int base);
        for (int i = 0; i < 64; i++) begin
            #1;
            check("fetch_re", 32'(ram_re), 1);
            check("fetch_addr", 32'(ram_addr), 32'(base + i));
            check("fetch_busy", 32'(busy), 1);
            @(negedge clk_pix);
        end
        #1;
        check("drain_busy", 32'(busy), 1);
        check("drain_re", 32'(ram_re), 0);
        @(negedge clk_pix);
        #1;
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic expect_disp(input logic [5:0] c, input logic [7:0] exp);
        @(negedge clk_pix);
        disp_col = c;
        @(negedge clk_pix);
        #1;
        check("disp_char", 32'(disp_char), 32'(exp));
    endtask

    task automatic pulse_line(input logic signed [10:0] y);
        @(negedge clk_pix);
        line = 1'b1;
        sy   = y;
        @(negedge clk_pix);
        line = 1'b0;
    endtask

    initial begin
        rst_pix = 1'b1; line = 1'b0; sy = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; disp_col = '0;
        repeat (3) @(negedge clk_pix);
        rst_pix = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_ram_re", 32'(ram_re), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_disp_char", 32'(disp_char), 0);

        // sy=-1 prefetches row 0; busy lags the trigger by one cycle
        @(negedge clk_pix);
        line = 1'b1; sy = -11'sd1;
        #1;
        check("trig_busy_lag", 32'(busy), 0);
        check("trig_ram_re", 32'(ram_re), 0);
        @(negedge clk_pix);
        line = 1'b0;
        expect_fetch(0);

        // sy=0 swaps only
        pulse_line(11'sd0);
        #1;
        check("swap_no_fetch", 32'(busy), 0);
        expect_disp(6'd0, pat(0));
        expect_disp(6'd5, pat(5));
        expect_disp(6'd63, pat(63));

        // row 1
        pulse_line(11'sd15);
        expect_fetch(64);
        pulse_line(11'sd16);
        expect_disp(6'd5, pat(69));
        expect_disp(6'd63, pat(127));

        // row 3 with a CPU write held from the first fetch cycle
        pulse_line(11'sd47);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd100; cpu_wdata = 8'h41;
        for (int c = 0; c < 65; c++) begin
            if (c == 9) begin
                cpu_req = 1'b0; cpu_we = 1'b0;
            end
            #1;
            if (c == 8) begin
                check("starve_ack", 32'(cpu_ack), 1);
                check("starve_we", 32'(ram_we), 1);
                check("starve_re", 32'(ram_re), 0);
                check("starve_addr", 32'(ram_addr), 100);
                check("starve_wdata", 32'(ram_wdata), 32'h41);
            end else begin
                check("share_ack", 32'(cpu_ack), 0);
                check("share_re", 32'(ram_re), 1);
                check("share_addr", 32'(ram_addr), 32'(192 + ((c < 8) ? c : c - 1)));
            end
            check("share_busy", 32'(busy), 1);
            @(negedge clk_pix);
        end
        #1;
        check("share_drain", 32'(busy), 1);
        @(negedge clk_pix);
        #1;
        check("share_idle", 32'(busy), 0);

        // CPU read-back of the write, then a read of an unwritten location
        @(negedge clk_pix);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd100;
        #1;
        check("rd100_ack", 32'(cpu_ack), 1);
        check("rd100_re", 32'(ram_re), 1);
        check("rd100_addr", 32'(ram_addr), 100);
        @(negedge clk_pix);
        cpu_req = 1'b0;
        #1;
        check("rd100_data", 32'(cpu_rdata), 32'h41);
        check("rd100_ack_off", 32'(cpu_ack), 0);
        @(negedge clk_pix);
        #1;
        check("rd100_hold", 32'(cpu_rdata), 32'h41);

        @(negedge clk_pix);
        cpu_req = 1'b1; cpu_addr = 12'd7;
        #1;
        check("rd7_ack", 32'(cpu_ack), 1);
        check("rd7_addr", 32'(ram_addr), 7);
        @(negedge clk_pix);
        cpu_req = 1'b0;
        #1;
        check("rd7_data", 32'(cpu_rdata), 32'(pat(7)));
        check("rd7_busy", 32'(busy), 0);
        check("rd7_re", 32'(ram_re), 0);

        // range edges: sy=-2 and sy=591 fall outside, sy=575 fetches the last row
        pulse_line(-11'sd2);
        #1;
        check("low_edge_idle", 32'(busy), 0);
        pulse_line(11'sd591);
        #1;
        check("high_edge_idle", 32'(busy), 0);
        pulse_line(11'sd575);
        expect_fetch(2304);
        pulse_line(11'sd576);
        expect_disp(6'd5, pat(2309));
        pulse_line(11'sd592);
        expect_disp(6'd5, pat(2309));
        check("edge_overrun", 32'(overrun), 0);

        // collision: row 2 trigger while row 1 is mid-fetch
        pulse_line(11'sd15);
        repeat (10) @(negedge clk_pix);
        line = 1'b1; sy = 11'sd31;
        #1;
        check("coll_pre_overrun", 32'(overrun), 0);
        @(negedge clk_pix);
        line = 1'b0;
        #1;
        check("coll_re", 32'(ram_re), 1);
        check("coll_addr0", 32'(ram_addr), 128);
        check("coll_overrun", 32'(overrun), 1);
        @(negedge clk_pix);
        #1;
        check("coll_addr1", 32'(ram_addr), 129);
        repeat (70) @(negedge clk_pix);
        #1;
        check("coll_done", 32'(busy), 0);
        check("coll_sticky", 32'(overrun), 1);

        // reset at fetch column 30 of row 4
        pulse_line(11'sd63);
        repeat (30) @(negedge clk_pix);
        #1;
        check("mid_addr", 32'(ram_addr), 286);
        rst_pix = 1'b1;
        #1;
        check("mid_rst_re", 32'(ram_re), 0);
        check("mid_rst_ack", 32'(cpu_ack), 0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        #1;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_re", 32'(ram_re), 0);
        check("post_rst_ack", 32'(cpu_ack), 0);
        check("post_rst_overrun", 32'(overrun), 0);
        @(negedge clk_pix);
        #1;
        check("post_rst_quiet", 32'(ram_re), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_fetch_ctrl.md
Name: text_fetch_ctrl

Overview:
- Schedules the character-code fetch for the 2x-scaled text-mode display and shares the single-port text RAM between display fetch and a CPU port.
- Prefetches the next character row (COLS codes) into the back half of a double line buffer one scanline before that row is first drawn, then swaps buffers.
- The glyph lookup reads disp_char by column during active video.

Parameters:
- CORDW, 11, screen coordinate width (signed sy)
- COLS, 64, text columns per row
- ROWS, 37, text rows per frame
- GLYPH_LINES, 16, scanlines per text row (8-pixel glyph x2 scale; power of two)
- AW, $clog2(COLS*ROWS) = 12, text RAM address width
- STARVE, 8, maximum consecutive fetch grants while a CPU request waits

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  synchronous, active-high reset
- line  in  1  one-cycle pulse at start of each scanline; sy valid in that cycle
- sy  in  CORDW signed  vertical coordinate of the line starting (negative in blanking)
- ram_addr  out  AW  text RAM address = row*COLS + col
- ram_re  out  1  RAM read strobe; data valid on ram_rdata next cycle
- ram_we  out  1  RAM write strobe
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data (1-cycle latency)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle grant pulse
- cpu_rdata  out  8  read data, valid the cycle after cpu_ack
- disp_col  in  $clog2(COLS)  column currently being drawn
- disp_char  out  8  front-buffer code at disp_col, registered (1-cycle latency)
- busy  out  1  fetch in progress
- overrun  out  1  sticky: fetch or swap collided with an unfinished fetch

Behaviour:
- Reset: all outputs 0; state IDLE; front_sel 0; STARVE counter 0; overrun 0. Line-buffer contents are not reset.
- Trigger:
  - On line with N = sy+1 in [0, ROWS*GLYPH_LINES-1] and N mod GLYPH_LINES == 0, start a fetch of row N/GLYPH_LINES into the back buffer.
  - sy = -1 therefore fetches row 0.
- Swap:
  - On line with sy in [0, ROWS*GLYPH_LINES-1] and sy mod GLYPH_LINES == 0, toggle front_sel in the same cycle.
  - Swap and trigger never coincide, because GLYPH_LINES > 1.
- FSM:
  - IDLE -> FETCH on trigger. busy = 1 from the next cycle.
  - FETCH: each granted cycle issues ram_re with address row*COLS+col, then col++. After col COLS-1 is issued -> DRAIN.
  - DRAIN: wait one cycle for the final read data -> IDLE. busy = 0 in IDLE.
  - Return data is written to back[col_d], where col_d is col delayed one cycle, qualified by a delayed valid bit.
- Arbitration:
  - In FETCH, fetch owns the RAM.
  - If cpu_req has been pending for STARVE consecutive fetch grants, the next cycle goes to the CPU (cpu_ack, fetch stalls one cycle, counter clears).
  - In IDLE or DRAIN, a pending cpu_req is granted immediately.
  - Only one RAM access per cycle. ram_we is asserted only for CPU writes.
- CPU read: cpu_rdata = ram_rdata, captured the cycle after cpu_ack. It is held until the next CPU read.
- Collisions:
  - A trigger while not IDLE aborts the current fetch and restarts at col 0 with the new row; overrun is set.
  - A swap while busy still swaps, and overrun is set.
  - An in-flight return beat from the aborted fetch is discarded.
- Worst-case fetch length is COLS + ceil(COLS/STARVE) + 1 = 73 cycles, well under one line.
- Reset mid-fetch: returns to IDLE the next cycle; no RAM strobes; the pending return beat is dropped.

Test Plan:
- Reset, then line with sy=-1 -> 64 reads at addresses 0..63 on consecutive cycles; busy high for 65 cycles; back buffer = RAM[0..63].
- line with sy=0 -> front_sel toggles; disp_col=5 gives disp_char = RAM[5] one cycle later. line with sy=15 -> fetch addresses 64..127.
- cpu_req write (addr 100, data 0x41) held throughout a fetch -> cpu_ack after 8 fetch reads; fetch completes in 65+1 cycles; a later CPU read of addr 100 returns 0x41.
- CPU read of addr 7 while IDLE -> cpu_ack in the same cycle; cpu_rdata = RAM[7] next cycle; no fetch activity.
- line with sy=31 issued mid-fetch of row 1 (forced) -> fetch restarts at address 128; overrun=1 and stays 1 until rst_pix.
- Assert rst_pix at fetch col 30 -> next cycle busy=0, ram_re=0, cpu_ack=0, overrun=0.
